// File: rtl/char_rom_pkg.sv
// Shared constants and response-owner tag for the character glyph RAM arbiter.
package char_rom_pkg;
    localparam int CHAR_CODE_W = 7;
    localparam int GLYPH_ROW_W = 4;
    localparam int ROM_ADDR_W  = 11;
    localparam int ROM_DATA_W  = 16;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_CPU_RD
    } owner_e;
endpackage

// File: rtl/char_rom_resp_pipe.sv
// Two-stage owner tag that follows each RAM access, captures DO one cycle after
// the grant, and steers it to the display or CPU response port.
module char_rom_resp_pipe
    import char_rom_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  owner_e                own_i,
    input  logic [ROM_DATA_W-1:0] rom_do_i,
    output logic                  disp_valid_o,
    output logic [ROM_DATA_W-1:0] disp_data_o,
    output logic                  cpu_rvalid_o,
    output logic [ROM_DATA_W-1:0] cpu_rdata_o
);

    owner_e                own1_q;
    owner_e                own2_q;
    logic [ROM_DATA_W-1:0] disp_data_q;
    logic [ROM_DATA_W-1:0] cpu_data_q;

    // Stage 1 marks the cycle DO is valid; each port keeps its last word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            own1_q      <= OWN_NONE;
            own2_q      <= OWN_NONE;
            disp_data_q <= '0;
            cpu_data_q  <= '0;
        end else begin
            own1_q <= own_i;
            own2_q <= own1_q;
            if (own1_q == OWN_DISP)   disp_data_q <= rom_do_i;
            if (own1_q == OWN_CPU_RD) cpu_data_q  <= rom_do_i;
        end
    end

    assign disp_valid_o = (own2_q == OWN_DISP);
    assign cpu_rvalid_o = (own2_q == OWN_CPU_RD);
    assign disp_data_o  = disp_data_q;
    assign cpu_rdata_o  = cpu_data_q;

endmodule

// File: rtl/char_rom_arbiter.sv
// Arbitrates the single-port glyph RAM between the text renderer (fixed priority)
// and the CPU, with a starvation guard that periodically forces the CPU ahead.
module char_rom_arbiter
    import char_rom_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int WRITE_ALLOW  = 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   DISP_REQ,
    input  logic [CHAR_CODE_W-1:0] DISP_CHAR,
    input  logic [GLYPH_ROW_W-1:0] DISP_ROW,
    output logic                   DISP_GNT,
    output logic                   DISP_VALID,
    output logic [ROM_DATA_W-1:0]  DISP_DATA,
    input  logic                   CPU_REQ,
    input  logic                   CPU_WE,
    input  logic [ROM_ADDR_W-1:0]  CPU_ADDR,
    input  logic [ROM_DATA_W-1:0]  CPU_WDATA,
    output logic                   CPU_GNT,
    output logic                   CPU_RVALID,
    output logic [ROM_DATA_W-1:0]  CPU_RDATA,
    output logic [ROM_ADDR_W-1:0]  ROM_ADDR,
    output logic [ROM_DATA_W-1:0]  ROM_DI,
    output logic                   ROM_EN,
    output logic [1:0]             ROM_WE,
    output logic                   ROM_REGCE,
    output logic                   ROM_RST,
    input  logic [ROM_DATA_W-1:0]  ROM_DO
);

    localparam int             SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0]  LIMIT = SW'(STARVE_LIMIT);
    localparam logic           WA    = (WRITE_ALLOW != 0);

    logic [SW-1:0] starve_q, starve_d;
    logic          cpu_force;
    logic          disp_gnt, cpu_gnt;
    owner_e        own;

    // Grants are qualified by RST_N so every output reads 0 while held in reset.
    always_comb begin
        cpu_force = (STARVE_LIMIT != 0) && (starve_q == LIMIT);
        disp_gnt  = RST_N && DISP_REQ && !(CPU_REQ && cpu_force);
        cpu_gnt   = RST_N && CPU_REQ && !disp_gnt;
    end

    always_comb begin
        starve_d = '0;
        if (CPU_REQ && !cpu_gnt)
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) starve_q <= '0;
        else        starve_q <= starve_d;
    end

    always_comb begin
        ROM_EN   = disp_gnt | cpu_gnt;
        ROM_ADDR = '0;
        ROM_DI   = '0;
        ROM_WE   = 2'b00;
        own      = OWN_NONE;
        if (disp_gnt) begin
            ROM_ADDR = {DISP_CHAR, DISP_ROW};
            own      = OWN_DISP;
        end else if (cpu_gnt) begin
            ROM_ADDR = CPU_ADDR;
            ROM_DI   = CPU_WDATA;
            ROM_WE   = {2{CPU_WE & WA}};
            // Writes, dropped or not, never produce a response.
            own      = CPU_WE ? OWN_NONE : OWN_CPU_RD;
        end
    end

    assign DISP_GNT  = disp_gnt;
    assign CPU_GNT   = cpu_gnt;
    assign ROM_REGCE = 1'b0;
    assign ROM_RST   = 1'b0;

    char_rom_resp_pipe u_resp (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .own_i        (own),
        .rom_do_i     (ROM_DO),
        .disp_valid_o (DISP_VALID),
        .disp_data_o  (DISP_DATA),
        .cpu_rvalid_o (CPU_RVALID),
        .cpu_rdata_o  (CPU_RDATA)
    );

endmodule

// File: doc/char_rom_arbiter.md
Name: char_rom_arbiter

Overview:
- Shares the single-port 2048x16 character glyph RAM between two requesters: the text-mode display renderer, which fetches glyph rows, and the CPU, which reads and reprograms the font.
- Display has fixed priority; a starvation guard bounds CPU wait.
- Drives the glyph RAM's ADDR/DI/EN/WE/REGCE/RST pins and routes read data back to the owning requester with a fixed latency.

Parameters:
STARVE_LIMIT, 8, consecutive denied CPU cycles before the CPU is forced ahead of display; 0 = strict display priority
WRITE_ALLOW, 1, 1 = CPU writes reach the RAM; 0 = CPU writes are granted and silently dropped

Ports:
CLK  in  1  single clock, rising edge
RST_N  in  1  asynchronous active-low reset
DISP_REQ  in  1  display fetch request, held until granted
DISP_CHAR  in  7  character code
DISP_ROW  in  4  glyph row 0..15
DISP_GNT  out  1  display request accepted this cycle
DISP_VALID  out  1  one-cycle pulse, DISP_DATA valid
DISP_DATA  out  16  glyph row bits, MSB = leftmost pixel
CPU_REQ  in  1  CPU request, held until granted
CPU_WE  in  1  1 = write, 0 = read
CPU_ADDR  in  11  word address
CPU_WDATA  in  16  write data
CPU_GNT  out  1  CPU request accepted this cycle
CPU_RVALID  out  1  one-cycle pulse, CPU_RDATA valid (reads only)
CPU_RDATA  out  16  read data
ROM_ADDR  out  11  to glyph RAM ADDR
ROM_DI  out  16  to glyph RAM DI
ROM_EN  out  1  to glyph RAM EN
ROM_WE  out  2  to glyph RAM WE
ROM_REGCE  out  1  tied 0 (RAM output register unused)
ROM_RST  out  1  tied 0
ROM_DO  in  16  from glyph RAM DO

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0; starvation counter 0; response pipeline cleared. Requests granted before reset never produce a response.
- Grant is combinational, at most one per cycle.
  - cpu_force = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_LIMIT).
  - DISP_GNT = DISP_REQ && !(CPU_REQ && cpu_force).
  - CPU_GNT = CPU_REQ && !DISP_GNT.
- RAM drive, combinational from the winner:
  - ROM_EN = DISP_GNT | CPU_GNT.
  - Display grant: ROM_ADDR = {DISP_CHAR, DISP_ROW}, ROM_WE = 0.
  - CPU grant: ROM_ADDR = CPU_ADDR, ROM_DI = CPU_WDATA, ROM_WE = {2{CPU_WE & WRITE_ALLOW}}.
  - Idle: ROM_ADDR, ROM_DI and ROM_WE are 0.
- Latency: grant in cycle N; RAM DO valid in N+1; the arbiter registers ROM_DO at the end of N+1; VALID pulses in cycle N+2.
  - DATA holds its last value until the next response for that port.
  - A CPU write produces no CPU_RVALID.
  - Throughput is 1 access per cycle; back-to-back grants give back-to-back VALIDs in grant order.
- Owner tag pipeline: 2 stages, {none, disp, cpu_rd}, advancing every cycle with no stall. Requesters must always accept responses.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when CPU_REQ && !CPU_GNT.
  - Clears when CPU_GNT or !CPU_REQ.
  - Width is $clog2(STARVE_LIMIT+1), minimum 1.
- Requester rules:
  - Address and data must stay stable while REQ is high and not granted.
  - Withdrawing REQ before grant is legal; no access occurs.
  - After grant, the requester may change inputs or issue a new request the next cycle.
- Simultaneous requests: display wins unless cpu_force; under cpu_force the CPU wins exactly one cycle, then the counter clears.
- Reset asserted mid-access: the access is abandoned; a RAM write already clocked stands.

Decomposition:
- Package char_rom_pkg holds:
  - constants CHAR_CODE_W=7, GLYPH_ROW_W=4, ROM_ADDR_W=11, ROM_DATA_W=16;
  - owner enum {OWN_NONE, OWN_DISP, OWN_CPU_RD}.
- One sub-module, char_rom_resp_pipe: the 2-stage owner tag plus data capture, demultiplexing to the DISP/CPU outputs.
- Arbitration and the starvation counter stay in the top.

Test Plan:
- Reset, then DISP_REQ with CHAR=0x41, ROW=3 -> DISP_GNT and ROM_ADDR=0x413 in the same cycle; DISP_VALID with DISP_DATA=0x1830 two cycles later; all outputs 0 during reset.
- CPU write ADDR=0x7E0, WDATA=0xA5A5, then CPU read 0x7E0 -> ROM_WE=2'b11 on the write grant; CPU_RVALID with CPU_RDATA=0xA5A5; no RVALID for the write. With WRITE_ALLOW=0: ROM_WE=0 and the read returns the original contents.
- DISP_REQ held continuously, CPU_REQ read from cycle 0, STARVE_LIMIT=8 -> CPU_GNT in cycle 8 exactly; DISP_GNT low that cycle only; counter back to 0. With STARVE_LIMIT=0 -> the CPU is never granted.
- Alternating grants DISP(0x20,0), CPU rd 0x000, DISP(0x41,3) -> VALIDs on consecutive cycles in the same order, each routed to the correct port with correct data.
- RST_N pulsed low one cycle after a grant -> no VALID follows; DATA outputs read 0.
- CPU_REQ withdrawn before grant while display busy -> no CPU access and no RVALID; counter clears.
